// File: rtl/rv32_pkg.sv
// Shared types and widths for the RV32 retire path.
// Optional feature macro used by writeback_unit: WB_BYPASS_EN.
package rv32_pkg;

  localparam int XLEN    = 32;
  localparam int NUM_REG = 32;
  localparam int IDX_W   = $clog2(NUM_REG);

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_op_e;

  typedef enum logic {
    WB_IDLE,
    WB_WAIT_MEM
  } wb_state_e;

endpackage

// File: rtl/writeback_unit_load_extend.sv
// Combinational load aligner: picks the byte/halfword lane out of the memory word
// and sign- or zero-extends it; unknown load types pass the whole word through.
module load_extend
  import rv32_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] ext_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane select followed by extension according to the load type
  always_comb begin
    byte_s = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_s = rdata_i[{addr_lo_i[1], 4'b0000} +: 16];
    ext_o  = rdata_i;
    case (funct3_i)
      LB:      ext_o = {{(XLEN-8){byte_s[7]}}, byte_s};
      LH:      ext_o = {{(XLEN-16){half_s[15]}}, half_s};
      LBU:     ext_o = {{(XLEN-8){1'b0}}, byte_s};
      LHU:     ext_o = {{(XLEN-16){1'b0}}, half_s};
      LW:      ext_o = rdata_i;
      default: ext_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Retire stage driving the register-file write port for ALU results and loads.
// Define WB_BYPASS_EN to expose the next-cycle write as a forwarding bypass.
module writeback_unit
  import rv32_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_valid,
  output logic             ex_ready,
  input  logic [IDX_W-1:0] ex_rd,
  input  logic [XLEN-1:0]  ex_result,
  input  logic             ex_is_load,
  input  logic [2:0]       ex_funct3,
  input  logic [1:0]       ex_addr_lo,
  input  logic             mem_rvalid,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             rf_wen,
  output logic [IDX_W-1:0] rf_rd,
  output logic [XLEN-1:0]  rf_rdv,
`ifdef WB_BYPASS_EN
  output logic             byp_valid,
  output logic [IDX_W-1:0] byp_rd,
  output logic [XLEN-1:0]  byp_val,
`endif
  output logic             ld_pend,
  output logic [IDX_W-1:0] ld_pend_rd
);

  wb_state_e        state_q, state_d;
  logic [IDX_W-1:0] cap_rd_q, cap_rd_d;
  logic [2:0]       cap_funct3_q, cap_funct3_d;
  logic [1:0]       cap_addr_q, cap_addr_d;
  logic             rf_wen_q, rf_wen_d;
  logic [IDX_W-1:0] rf_rd_q, rf_rd_d;
  logic [XLEN-1:0]  rf_rdv_q, rf_rdv_d;
  logic [XLEN-1:0]  ld_ext_s;

  load_extend u_load_extend (
    .funct3_i  (cap_funct3_q),
    .addr_lo_i (cap_addr_q),
    .rdata_i   (mem_rdata),
    .ext_o     (ld_ext_s)
  );

  // Next-state, capture and write-port logic; x0 writes are dropped here
  always_comb begin
    state_d      = state_q;
    cap_rd_d     = cap_rd_q;
    cap_funct3_d = cap_funct3_q;
    cap_addr_d   = cap_addr_q;
    rf_wen_d     = 1'b0;
    rf_rd_d      = rf_rd_q;
    rf_rdv_d     = rf_rdv_q;
    case (state_q)
      WB_IDLE: begin
        if (ex_valid) begin
          if (ex_is_load) begin
            cap_rd_d     = ex_rd;
            cap_funct3_d = ex_funct3;
            cap_addr_d   = ex_addr_lo;
            state_d      = WB_WAIT_MEM;
          end else if (ex_rd != {IDX_W{1'b0}}) begin
            rf_wen_d = 1'b1;
            rf_rd_d  = ex_rd;
            rf_rdv_d = ex_result;
          end else begin
            rf_wen_d = 1'b0;
          end
        end else begin
          rf_wen_d = 1'b0;
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d = WB_IDLE;
          if (cap_rd_q != {IDX_W{1'b0}}) begin
            rf_wen_d = 1'b1;
            rf_rd_d  = cap_rd_q;
            rf_rdv_d = ld_ext_s;
          end else begin
            rf_wen_d = 1'b0;
          end
        end else begin
          state_d = WB_WAIT_MEM;
        end
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WB_IDLE;
      cap_rd_q     <= {IDX_W{1'b0}};
      cap_funct3_q <= 3'b000;
      cap_addr_q   <= 2'b00;
      rf_wen_q     <= 1'b0;
      rf_rd_q      <= {IDX_W{1'b0}};
      rf_rdv_q     <= {XLEN{1'b0}};
    end else begin
      state_q      <= state_d;
      cap_rd_q     <= cap_rd_d;
      cap_funct3_q <= cap_funct3_d;
      cap_addr_q   <= cap_addr_d;
      rf_wen_q     <= rf_wen_d;
      rf_rd_q      <= rf_rd_d;
      rf_rdv_q     <= rf_rdv_d;
    end
  end

  assign ex_ready   = (state_q == WB_IDLE);
  assign rf_wen     = rf_wen_q;
  assign rf_rd      = rf_rd_q;
  assign rf_rdv     = rf_rdv_q;
  assign ld_pend    = (state_q == WB_WAIT_MEM);
  assign ld_pend_rd = (state_q == WB_WAIT_MEM) ? cap_rd_q : {IDX_W{1'b0}};

`ifdef WB_BYPASS_EN
  // Bypass mirrors the value the write port will present next cycle
  assign byp_valid = rf_wen_d;
  assign byp_rd    = rf_rd_d;
  assign byp_val   = rf_rdv_d;
`endif

endmodule
